wave_voice_scheduler: RTL and testbench

- Sequences the four-voice triangle-wave datapath once per audio sample period.
- Owns the four 24-bit phase accumulators, programmed by frequency control words (FCWs).
- Issues one request per sample tick, holds the phase snapshot stable until the datapath returns, then mixes the four 21-bit waves into one signed sample.
- Delivers the sample to the audio output path over a valid/ready handshake.

---
 rtl/wave_voice_scheduler.sv | 136 +++++++++++++
 tb/tb_wave_voice_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_voice_scheduler.sv
// Four-voice triangle-wave sequencer: owns the phase accumulators, issues one datapath
// request per sample tick, mixes the returned waves and hands the sample downstream.
module wave_voice_scheduler #(
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned WAVE_W   = 21,
  parameter int unsigned TIMEOUT  = 64,
  localparam int unsigned SAMPLE_W = 24,
  localparam int unsigned OVR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [PHASE_W-1:0]  cfg_wdata,
  output logic                gen_in_valid,
  output logic [PHASE_W-1:0]  gen_phase_1,
  output logic [PHASE_W-1:0]  gen_phase_2,
  output logic [PHASE_W-1:0]  gen_phase_3,
  output logic [PHASE_W-1:0]  gen_phase_4,
  input  logic [WAVE_W-1:0]   gen_wave_1,
  input  logic [WAVE_W-1:0]   gen_wave_2,
  input  logic [WAVE_W-1:0]   gen_wave_3,
  input  logic [WAVE_W-1:0]   gen_wave_4,
  input  logic                gen_out_valid,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                busy,
  output logic [OVR_W-1:0]    overrun_cnt,
  output logic                timeout_err
);

  localparam int unsigned NV   = 4;
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MIX, HOLD} state_t;

  state_t              state, state_next;
  logic                timeout_hit;
  logic [TO_W-1:0]     wait_cnt;
  logic [NV-1:0]       mask;
  logic [PHASE_W-1:0]  fcw     [NV];
  logic [PHASE_W-1:0]  acc     [NV];
  logic [PHASE_W-1:0]  phase_q [NV];
  logic [WAVE_W-1:0]   wave_in [NV];
  logic [WAVE_W-1:0]   wave_q  [NV];
  logic [SAMPLE_W-1:0] mix_sum;

  assign wave_in[0] = gen_wave_1;
  assign wave_in[1] = gen_wave_2;
  assign wave_in[2] = gen_wave_3;
  assign wave_in[3] = gen_wave_4;

  assign gen_phase_1 = phase_q[0];
  assign gen_phase_2 = phase_q[1];
  assign gen_phase_3 = phase_q[2];
  assign gen_phase_4 = phase_q[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:  if (sample_tick) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (gen_out_valid) begin
          state_next = MIX;
        end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      MIX:   state_next = HOLD;
      HOLD:  if (sample_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured waves are already sign-extension-safe: disabled voices were zeroed at capture.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NV; i++) begin
      mix_sum = mix_sum + {{(SAMPLE_W - WAVE_W){wave_q[i][WAVE_W-1]}}, wave_q[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gen_in_valid <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      sample_data  <= '0;
      overrun_cnt  <= '0;
      timeout_err  <= 1'b0;
      wait_cnt     <= '0;
      mask         <= '0;
      for (int i = 0; i < NV; i++) begin
        fcw[i]     <= '0;
        acc[i]     <= '0;
        phase_q[i] <= '0;
        wave_q[i]  <= '0;
      end
    end else begin
      gen_in_valid <= (state_next == ISSUE);
      sample_valid <= (state_next == HOLD);
      busy         <= (state_next != IDLE);
      wait_cnt     <= (state == WAIT) ? wait_cnt + TO_W'(1) : '0;

      // Snapshot is taken only on the tick that launches a request.
      for (int i = 0; i < NV; i++) begin
        if (state == IDLE && sample_tick) phase_q[i] <= acc[i];
        if (!mask[i])                     acc[i] <= '0;
        else if (state == ISSUE)          acc[i] <= acc[i] + fcw[i];
        if (state == WAIT && gen_out_valid) wave_q[i] <= mask[i] ? wave_in[i] : '0;
      end

      if (state == MIX) sample_data <= mix_sum;

      if (cfg_we && !cfg_addr[2])       fcw[cfg_addr[1:0]] <= cfg_wdata;
      if (cfg_we && cfg_addr == 3'd4)   mask <= cfg_wdata[NV-1:0];

      if (sample_tick && state != IDLE && overrun_cnt != {OVR_W{1'b1}})
        overrun_cnt <= overrun_cnt + OVR_W'(1);

      if (timeout_hit)                      timeout_err <= 1'b1;
      else if (cfg_we && cfg_addr == 3'd4)  timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wave_voice_scheduler.sv
// Directed bench for wave_voice_scheduler: phase stepping, wrap, mixing, back-pressure,
// overrun counting, timeout and mid-request reset.
module tb_wave_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [23:0] cfg_wdata = '0;
  logic        gen_in_valid;
  logic [23:0] gen_phase_1, gen_phase_2, gen_phase_3, gen_phase_4;
  logic [20:0] gen_wave_1 = '0, gen_wave_2 = '0, gen_wave_3 = '0, gen_wave_4 = '0;
  logic        gen_out_valid = 1'b0;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic [23:0] sample_data;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  wave_voice_scheduler dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .gen_in_valid(gen_in_valid),
    .gen_phase_1(gen_phase_1), .gen_phase_2(gen_phase_2),
    .gen_phase_3(gen_phase_3), .gen_phase_4(gen_phase_4),
    .gen_wave_1(gen_wave_1), .gen_wave_2(gen_wave_2),
    .gen_wave_3(gen_wave_3), .gen_wave_4(gen_wave_4),
    .gen_out_valid(gen_out_valid),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .busy(busy), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [23:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // Called in WAIT: return the current waves, then expect the mixed sample and accept it.
  task automatic finish_sample(input string tag, input logic [23:0] exp);
    gen_out_valid = 1'b1;
    step();
    gen_out_valid = 1'b0;
    chk({tag, "_valid_mix"}, sample_valid, 1'b0);
    step();
    chk({tag, "_valid"}, sample_valid, 1'b1);
    chk({tag, "_data"}, sample_data, exp);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    chk({tag, "_valid_drop"}, sample_valid, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [23:0] exp_p1 [3];
    logic [23:0] exp_p2 [3];

    repeat (2) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_valid", gen_in_valid, 1'b0);
    chk("rst_sample_valid", sample_valid, 1'b0);
    chk("rst_sample_data", sample_data, 24'h0);
    chk("rst_overrun", overrun_cnt, 8'h0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_phase1", gen_phase_1, 24'h0);
    rst = 1'b1;
    step();

    // Phase stepping, one-cycle request pulse
    cfg_write(3'd4, 24'h00000F);
    cfg_write(3'd0, 24'h000100);
    cfg_write(3'd1, 24'h000010);
    exp_p1 = '{24'h000000, 24'h000100, 24'h000200};
    exp_p2 = '{24'h000000, 24'h000010, 24'h000020};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_in_valid", gen_in_valid, 1'b1);
      chk("t1_phase1", gen_phase_1, exp_p1[k]);
      chk("t1_phase2", gen_phase_2, exp_p2[k]);
      step();
      chk("t1_in_valid_one", gen_in_valid, 1'b0);
      chk("t1_busy", busy, 1'b1);
      finish_sample("t1", 24'h000000);
    end

    // Wrap: clear voice 1 via mask, then FCW=all ones
    cfg_write(3'd0, 24'hFFFFFF);
    cfg_write(3'd4, 24'h00000E);
    cfg_write(3'd4, 24'h00000F);
    exp_p1 = '{24'h000000, 24'hFFFFFF, 24'hFFFFFE};
    exp_p2 = '{24'h000030, 24'h000040, 24'h000050};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_phase1", gen_phase_1, exp_p1[k]);
      chk("t2_phase2", gen_phase_2, exp_p2[k]);
      step();
      finish_sample("t2", 24'h000000);
    end

    // Mixing with a 7-cycle datapath; FCW write mid-request leaves snapshot alone
    gen_wave_1 = 21'h0FFFFF; gen_wave_2 = 21'h0FFFFF;
    gen_wave_3 = 21'h100000; gen_wave_4 = 21'h1FFFFF;
    tick();
    chk("t3_phase1", gen_phase_1, 24'hFFFFFD);
    step();
    cfg_write(3'd0, 24'h000200);
    chk("t3_phase_hold", gen_phase_1, 24'hFFFFFD);
    repeat (3) step();
    chk("t3_phase_hold2", gen_phase_1, 24'hFFFFFD);
    step();
    finish_sample("t3_all", 24'h0FFFFD);
    cfg_write(3'd4, 24'h000003);
    tick();
    chk("t3_phase1b", gen_phase_1, 24'hFFFFFC);
    chk("t3_phase3_off", gen_phase_3, 24'h000000);
    repeat (6) step();
    finish_sample("t3_mask3", 24'h1FFFFE);

    // Stray result strobe while idle is ignored
    gen_out_valid = 1'b1;
    step();
    gen_out_valid = 1'b0;
    step();
    chk("stray_busy", busy, 1'b0);
    chk("stray_valid", sample_valid, 1'b0);

    // Back-pressure in HOLD with dropped ticks
    cfg_write(3'd4, 24'h00000F);
    gen_wave_1 = 21'h000001; gen_wave_2 = 21'h000002;
    gen_wave_3 = 21'h1FFFFD; gen_wave_4 = 21'h000004;
    tick();
    chk("t4_phase1", gen_phase_1, 24'h0001FC);
    step();
    gen_out_valid = 1'b1;
    step();
    gen_out_valid = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      sample_tick = (i == 5 || i == 12);
      step();
      sample_tick = 1'b0;
      chk("t4_hold_valid", sample_valid, 1'b1);
      chk("t4_hold_data", sample_data, 24'h000004);
    end
    chk("t4_overrun2", overrun_cnt, 8'd2);
    sample_ready = 1'b1;
    sample_tick = 1'b1;
    step();
    sample_ready = 1'b0;
    sample_tick = 1'b0;
    chk("t4_valid_drop", sample_valid, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_overrun3", overrun_cnt, 8'd3);
    step();
    chk("t4_no_issue", gen_in_valid, 1'b0);

    // Timeout: datapath never answers
    tick();
    step();
    repeat (63) step();
    chk("t5_pre_err", timeout_err, 1'b0);
    chk("t5_pre_busy", busy, 1'b1);
    step();
    chk("t5_err", timeout_err, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_valid", sample_valid, 1'b0);
    step();
    chk("t5_sticky", timeout_err, 1'b1);
    cfg_write(3'd4, 24'h00000F);
    chk("t5_clear", timeout_err, 1'b0);

    // Reset while waiting; late result must not produce a sample
    tick();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_overrun", overrun_cnt, 8'd0);
    chk("t6_data", sample_data, 24'h0);
    chk("t6_phase1", gen_phase_1, 24'h0);
    step();
    rst = 1'b1;
    gen_out_valid = 1'b1;
    step();
    gen_out_valid = 1'b0;
    step();
    step();
    chk("t6_late_valid", sample_valid, 1'b0);
    chk("t6_late_busy", busy, 1'b0);
    chk("t6_late_data", sample_data, 24'h0);
    chk("t6_late_in_valid", gen_in_valid, 1'b0);
    chk("t6_late_timeout", timeout_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
